// File: rtl/drw_pkg.sv
// -----------------------------------------------------------------------------
// drw_pkg
// Shared types and constants for the drawing-engine line controller.
//   state_t      : line controller FSM states
//   PIX_BYTES    : bytes per pixel (one burst beat)
//   BOUNDARY     : bursts must not cross this byte boundary
//   PAGE_PIX     : pixels per boundary page
//   CMD_PATBLT / CMD_BITBLT : CMD_MODE encodings
//   min_u11()    : unsigned minimum of two 11-bit values
// -----------------------------------------------------------------------------
package drw_pkg;

   localparam int PIX_BYTES = 4;
   localparam int BOUNDARY  = 4096;
   localparam int PAGE_PIX  = BOUNDARY / PIX_BYTES;

   localparam logic CMD_PATBLT = 1'b0;
   localparam logic CMD_BITBLT = 1'b1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CALC,
      S_RD_SRC,
      S_RD_DST,
      S_WR,
      S_NEXT,
      S_DRAIN
   } state_t;

   function automatic logic [10:0] min_u11(input logic [10:0] a, input logic [10:0] b);
      return (a < b) ? a : b;
   endfunction

endpackage

// File: rtl/drw_burst_calc.sv
// -----------------------------------------------------------------------------
// drw_burst_calc
// Combinational chunk-size computation for one burst:
//   chunk = min(remaining, MAX_BEATS, pixels left in the dst page,
//               pixels left in the src page when use_src_i is set)
// Ports:
//   dst_page_off_i : dst address bits [11:2] (pixel offset inside the page)
//   src_page_off_i : src address bits [11:2]
//   remaining_i    : pixels still to be transferred on this line
//   use_src_i      : include the src page limit (BITBLT)
//   chunk_o        : burst length in pixels, 1..MAX_BEATS when remaining_i>0
// -----------------------------------------------------------------------------
module drw_burst_calc
   import drw_pkg::*;
#(
   parameter int MAX_BEATS = 16
) (
   input  logic [9:0]  dst_page_off_i,
   input  logic [9:0]  src_page_off_i,
   input  logic [10:0] remaining_i,
   input  logic        use_src_i,
   output logic [4:0]  chunk_o
);

   logic [10:0] dst_room;
   logic [10:0] src_room;
   logic [10:0] lim;

   // NOTE: every variable written here gets a value before any condition,
   // otherwise the tool infers a latch to hold the old value.
   always_comb begin
      // Room is 1..PAGE_PIX, so an aligned address reports a full page.
      dst_room = 11'(PAGE_PIX) - {1'b0, dst_page_off_i};
      src_room = 11'(PAGE_PIX) - {1'b0, src_page_off_i};
      lim      = min_u11(remaining_i, 11'(MAX_BEATS));
      lim      = min_u11(lim, dst_room);
      if (use_src_i) begin
         lim = min_u11(lim, src_room);
      end
      chunk_o = 5'(lim);
   end

endmodule

// File: rtl/drw_linectrl.sv
// -----------------------------------------------------------------------------
// drw_linectrl
// Splits one drawing line into memory bursts. Each burst optionally reads the
// source texture (BITBLT), optionally reads back the destination (alpha
// blend), then writes the destination. Bursts never cross a 4 KiB page of the
// addresses involved and never exceed MAX_BEATS pixels. The line stays busy
// until every issued write burst has been acknowledged on WRESP_VALID.
// Ports:
//   CLK, ARST (async, active-high), SOFT_RST (sync soft reset)
//   LINE_START / LINE_BUSY        : line kick and in-progress flag
//   LINE_ADDR_DST, LINE_ADDR_SRC  : byte addresses, sampled on the kick
//   LINE_LEN, CMD_MODE, PARAM_BLEND : pixel count, 0:PATBLT 1:BITBLT, blend
//   RADDR_*  : read address channel (SEL 0:src 1:dst readback, LEN=beats-1)
//   WADDR_*  : write address channel (LEN=beats-1)
//   WRESP_VALID : one pulse per completed write burst
// -----------------------------------------------------------------------------
module drw_linectrl
   import drw_pkg::*;
#(
   parameter int MAX_BEATS = 16   // power of two, 1..16
) (
   input  logic        CLK,
   input  logic        ARST,
   input  logic        SOFT_RST,
   input  logic        LINE_START,
   output logic        LINE_BUSY,
   input  logic [31:0] LINE_ADDR_DST,
   input  logic [31:0] LINE_ADDR_SRC,
   input  logic [10:0] LINE_LEN,
   input  logic        CMD_MODE,
   input  logic        PARAM_BLEND,
   output logic        RADDR_VALID,
   input  logic        RADDR_READY,
   output logic [31:0] RADDR_ADDR,
   output logic [3:0]  RADDR_LEN,
   output logic        RADDR_SEL,
   output logic        WADDR_VALID,
   input  logic        WADDR_READY,
   output logic [31:0] WADDR_ADDR,
   output logic [3:0]  WADDR_LEN,
   input  logic        WRESP_VALID
);

   state_t      state_q, state_d;
   logic [31:0] dst_q, dst_d;
   logic [31:0] src_q, src_d;
   logic [10:0] rem_q, rem_d;
   logic [4:0]  chunk_q, chunk_d;
   logic        mode_q, mode_d;
   logic        blend_q, blend_d;
   logic        busy_q, busy_d;
   logic [8:0]  outs_q, outs_d;

   logic [4:0]  calc_chunk;
   logic [10:0] rem_after;
   logic [31:0] step;
   logic [3:0]  len_m1;
   logic        wr_inc;
   logic        wr_dec;

   drw_burst_calc #(
      .MAX_BEATS (MAX_BEATS)
   ) u_burst_calc (
      .dst_page_off_i (dst_q[11:2]),
      .src_page_off_i (src_q[11:2]),
      .remaining_i    (rem_q),
      .use_src_i      (mode_q == CMD_BITBLT),
      .chunk_o        (calc_chunk)
   );

   assign rem_after = rem_q - 11'(chunk_q);
   assign step      = {25'd0, chunk_q, 2'b00};   // chunk * PIX_BYTES
   assign len_m1    = 4'(chunk_q - 5'd1);

   // A response with nothing outstanding is dropped rather than wrapping.
   assign wr_inc = (state_q == S_WR) && WADDR_READY;
   assign wr_dec = WRESP_VALID && (outs_q != 9'd0);

   // ---------------------------------------------------------------- state reg
   // NOTE: clocked processes use non-blocking (<=) so every register samples
   // the pre-edge values of the others, independent of statement order.
   always_ff @(posedge CLK or posedge ARST) begin
      if (ARST) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // --------------------------------------------------------------- next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (LINE_START) begin
               state_d = (LINE_LEN == 11'd0) ? S_DRAIN : S_CALC;
            end
         end
         S_CALC: begin
            if (mode_q == CMD_BITBLT) begin
               state_d = S_RD_SRC;
            end else if (blend_q) begin
               state_d = S_RD_DST;
            end else begin
               state_d = S_WR;
            end
         end
         S_RD_SRC: begin
            if (RADDR_READY) begin
               state_d = blend_q ? S_RD_DST : S_WR;
            end
         end
         S_RD_DST: begin
            if (RADDR_READY) begin
               state_d = S_WR;
            end
         end
         S_WR: begin
            if (WADDR_READY) begin
               state_d = S_NEXT;
            end
         end
         S_NEXT: begin
            state_d = (rem_after != 11'd0) ? S_CALC : S_DRAIN;
         end
         S_DRAIN: begin
            if (outs_q == 9'd0) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (SOFT_RST) begin
         state_d = S_IDLE;
      end
   end

   // ------------------------------------------------------------------ outputs
   always_comb begin
      RADDR_VALID = 1'b0;
      RADDR_ADDR  = 32'd0;
      RADDR_LEN   = 4'd0;
      RADDR_SEL   = 1'b0;
      WADDR_VALID = 1'b0;
      WADDR_ADDR  = 32'd0;
      WADDR_LEN   = 4'd0;
      unique case (state_q)
         S_RD_SRC: begin
            RADDR_VALID = 1'b1;
            RADDR_SEL   = 1'b0;
            RADDR_ADDR  = {src_q[31:2], 2'b00};
            RADDR_LEN   = len_m1;
         end
         S_RD_DST: begin
            RADDR_VALID = 1'b1;
            RADDR_SEL   = 1'b1;
            RADDR_ADDR  = {dst_q[31:2], 2'b00};
            RADDR_LEN   = len_m1;
         end
         S_WR: begin
            WADDR_VALID = 1'b1;
            WADDR_ADDR  = {dst_q[31:2], 2'b00};
            WADDR_LEN   = len_m1;
         end
         default: ;
      endcase
   end

   assign LINE_BUSY = busy_q;

   // ----------------------------------------------------------------- datapath
   always_comb begin
      dst_d   = dst_q;
      src_d   = src_q;
      rem_d   = rem_q;
      chunk_d = chunk_q;
      mode_d  = mode_q;
      blend_d = blend_q;
      busy_d  = busy_q;
      unique case (state_q)
         S_IDLE: begin
            if (LINE_START) begin
               dst_d   = {LINE_ADDR_DST[31:2], 2'b00};
               src_d   = {LINE_ADDR_SRC[31:2], 2'b00};
               rem_d   = LINE_LEN;
               mode_d  = CMD_MODE;
               blend_d = PARAM_BLEND;
               busy_d  = 1'b1;
            end
         end
         S_CALC: chunk_d = calc_chunk;
         S_NEXT: begin
            dst_d = dst_q + step;   // wraps modulo 2^32
            if (mode_q == CMD_BITBLT) begin
               src_d = src_q + step;
            end
            rem_d = rem_after;
         end
         S_DRAIN: begin
            if (outs_q == 9'd0) begin
               busy_d = 1'b0;
            end
         end
         default: ;
      endcase
      if (SOFT_RST) begin
         dst_d   = 32'd0;
         src_d   = 32'd0;
         rem_d   = 11'd0;
         chunk_d = 5'd0;
         mode_d  = 1'b0;
         blend_d = 1'b0;
         busy_d  = 1'b0;
      end
   end

   always_comb begin
      outs_d = outs_q;
      unique case ({wr_inc, wr_dec})
         2'b10:   outs_d = outs_q + 9'd1;
         2'b01:   outs_d = outs_q - 9'd1;
         default: ;   // none, or both at once: unchanged
      endcase
      if (SOFT_RST) begin
         outs_d = 9'd0;
      end
   end

   always_ff @(posedge CLK or posedge ARST) begin
      if (ARST) begin
         dst_q   <= 32'd0;
         src_q   <= 32'd0;
         rem_q   <= 11'd0;
         chunk_q <= 5'd0;
         mode_q  <= 1'b0;
         blend_q <= 1'b0;
         busy_q  <= 1'b0;
         outs_q  <= 9'd0;
      end else begin
         dst_q   <= dst_d;
         src_q   <= src_d;
         rem_q   <= rem_d;
         chunk_q <= chunk_d;
         mode_q  <= mode_d;
         blend_q <= blend_d;
         busy_q  <= busy_d;
         outs_q  <= outs_d;
      end
   end

endmodule
